// File: rtl/ysyx_23060201_seq_if.sv
// Handshake and status bundle between the sequencer and its fetch,
// decode, load/store and register-file neighbours.
interface ysyx_23060201_seq_if;
  logic        ifu_req;
  logic        ifu_rdy;
  logic [31:0] inst_in;
  logic [31:0] inst_q;
  logic        is_load;
  logic        is_store;
  logic        is_ebreak;
  logic        lsu_req;
  logic        lsu_we;
  logic        lsu_rdy;
  logic        gpr_wen;
  logic        pc_en;
  logic        halt;
  logic        err;
  logic [2:0]  state;

  // Sequencer side: issues requests and strobes, consumes ready/decode.
  modport master (
    output ifu_req,
    input  ifu_rdy,
    input  inst_in,
    output inst_q,
    input  is_load,
    input  is_store,
    input  is_ebreak,
    output lsu_req,
    output lsu_we,
    input  lsu_rdy,
    output gpr_wen,
    output pc_en,
    output halt,
    output err,
    output state
  );

  // Memory / decode side of the same bundle.
  modport slave (
    input  ifu_req,
    output ifu_rdy,
    output inst_in,
    input  inst_q,
    output is_load,
    output is_store,
    output is_ebreak,
    input  lsu_req,
    input  lsu_we,
    output lsu_rdy,
    input  gpr_wen,
    input  pc_en,
    input  halt,
    input  err,
    input  state
  );
endinterface

// File: rtl/ysyx_23060201_seq.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, optional
// memory access, write-back. Bus waits are bounded by TIMEOUT; expiry
// parks the machine in ERR, ebreak parks it in HALT, both until reset.
module ysyx_23060201_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic                  clk,
  input logic                  rst,
  ysyx_23060201_seq_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [7:0] LP_TMO = TIMEOUT[7:0];

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_inst_q;
  logic        r_ifu_req;
  logic        r_lsu_req;
  logic        r_lsu_we;
  logic        r_gpr_wen;
  logic        r_pc_en;
  logic        r_halt;
  logic        r_err;

  state_t      w_nxt;
  logic [7:0]  w_cnt_nxt;
  logic [7:0]  w_cnt_inc;
  logic        w_is_mem;

  // A store flag wins over a simultaneous load flag, so memory-ness is
  // the OR of both and write direction follows is_store alone.
  assign w_is_mem  = bus.is_load | bus.is_store;
  assign w_cnt_inc = r_cnt + 8'd1;

  // Next-state and wait-counter selection; ready in the cycle the counter
  // would reach TIMEOUT is tested first, so it wins over the timeout.
  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_nxt     = S_FETCH;
        w_cnt_nxt = '0;
      end
      S_FETCH: begin
        if (bus.ifu_rdy) begin
          w_nxt = S_DECODE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == LP_TMO) w_nxt = S_ERR;
        end
      end
      S_DECODE: begin
        w_nxt = bus.is_ebreak ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (w_is_mem) begin
          w_nxt     = S_MEM;
          w_cnt_nxt = '0;
        end else begin
          w_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (bus.lsu_rdy) begin
          w_nxt = S_WB;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == LP_TMO) w_nxt = S_ERR;
        end
      end
      S_WB: begin
        w_nxt     = S_FETCH;
        w_cnt_nxt = '0;
      end
      S_HALT:  w_nxt = S_HALT;
      S_ERR:   w_nxt = S_ERR;
      default: w_nxt = S_IDLE;
    endcase
  end

  // State register plus outputs registered from the next state, so every
  // request and strobe is aligned exactly with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_inst_q  <= '0;
      r_ifu_req <= 1'b0;
      r_lsu_req <= 1'b0;
      r_lsu_we  <= 1'b0;
      r_gpr_wen <= 1'b0;
      r_pc_en   <= 1'b0;
      r_halt    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ifu_req <= (w_nxt == S_FETCH);
      r_lsu_req <= (w_nxt == S_MEM);
      r_lsu_we  <= (w_nxt == S_MEM) && bus.is_store;
      r_gpr_wen <= (w_nxt == S_WB) && !bus.is_store;
      r_pc_en   <= (w_nxt == S_WB);
      if (r_state == S_FETCH && bus.ifu_rdy) r_inst_q <= bus.inst_in;
      if (w_nxt == S_HALT) r_halt <= 1'b1;
      if (w_nxt == S_ERR)  r_err  <= 1'b1;
    end
  end

  assign bus.ifu_req = r_ifu_req;
  assign bus.inst_q  = r_inst_q;
  assign bus.lsu_req = r_lsu_req;
  assign bus.lsu_we  = r_lsu_we;
  assign bus.gpr_wen = r_gpr_wen;
  assign bus.pc_en   = r_pc_en;
  assign bus.halt    = r_halt;
  assign bus.err     = r_err;
  assign bus.state   = r_state;

endmodule

// File: tb/tb_ysyx_23060201_seq.sv
// Directed bench for the sequencer: a per-scenario expected trace is built
// from the instruction list and bus wait counts, then compared every cycle.
module tb_ysyx_23060201_seq;

  localparam int TMO = 4;
  localparam logic [31:0] ADDI   = 32'h00100093;
  localparam logic [31:0] ADDI2  = 32'h00200113;
  localparam logic [31:0] LW     = 32'h00002183;
  localparam logic [31:0] SW     = 32'h00312023;
  localparam logic [31:0] EBREAK = 32'h00100073;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ovr = 1'b0;
  always #5 clk = ~clk;

  ysyx_23060201_seq_if vif();

  ysyx_23060201_seq #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  // Decoder stand-in; ovr forces both load and store flags.
  assign vif.is_load   = ovr | (vif.inst_q[6:0] == 7'h03);
  assign vif.is_store  = ovr | (vif.inst_q[6:0] == 7'h23);
  assign vif.is_ebreak = (vif.inst_q == EBREAK);

  typedef struct packed {
    logic [2:0]  st;
    logic        ifu, lsu, we, gw, pe, h, e;
    logic [31:0] iq;
  } vec_t;

  vec_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_ifu, n_lsu;
  logic [31:0] p_ins[8];
  int          p_wf[8];
  int          p_wm[8];
  int          p_n;

  function automatic vec_t mk(logic [2:0] st, logic [31:0] iq);
    vec_t v;
    v     = '0;
    v.st  = st;
    v.iq  = iq;
    v.ifu = (st == 3'd1);
    v.lsu = (st == 3'd4);
    v.pe  = (st == 3'd5);
    v.h   = (st == 3'd6);
    v.e   = (st == 3'd7);
    return v;
  endfunction

  task automatic prog(int i, logic [31:0] ins, int wf, int wm);
    p_ins[i] = ins;
    p_wf[i]  = wf;
    p_wm[i]  = wm;
  endtask

  // Expected per-cycle trace: IDLE, then per instruction FETCH for wf+1
  // cycles, DECODE, EXEC, MEM for wm+1 cycles if memory, WB.
  task automatic build();
    logic [31:0] iq;
    vec_t        v;
    bit          ld, st;
    iq = '0;
    exp_q.delete();
    exp_q.push_back(mk(3'd0, iq));
    for (int i = 0; i < p_n; i++) begin
      if (p_wf[i] >= TMO) begin
        repeat (TMO) exp_q.push_back(mk(3'd1, iq));
        repeat (3) exp_q.push_back(mk(3'd7, iq));
        return;
      end
      repeat (p_wf[i] + 1) exp_q.push_back(mk(3'd1, iq));
      iq = p_ins[i];
      exp_q.push_back(mk(3'd2, iq));
      if (iq == EBREAK) begin
        repeat (3) exp_q.push_back(mk(3'd6, iq));
        return;
      end
      exp_q.push_back(mk(3'd3, iq));
      ld = ovr || (iq[6:0] == 7'h03);
      st = ovr || (iq[6:0] == 7'h23);
      if (ld || st) begin
        v    = mk(3'd4, iq);
        v.we = st;
        if (p_wm[i] >= TMO) begin
          repeat (TMO) exp_q.push_back(v);
          repeat (3) exp_q.push_back(mk(3'd7, iq));
          return;
        end
        repeat (p_wm[i] + 1) exp_q.push_back(v);
      end
      v    = mk(3'd5, iq);
      v.gw = !st;
      exp_q.push_back(v);
    end
  endtask

  task automatic check(string nm, vec_t want);
    vec_t got;
    got = {vif.state, vif.ifu_req, vif.lsu_req, vif.lsu_we, vif.gpr_wen,
           vif.pc_en, vif.halt, vif.err, vif.inst_q};
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got st=%0d ifu=%b lsu=%b we=%b gw=%b pe=%b h=%b e=%b iq=%h ; want st=%0d ifu=%b lsu=%b we=%b gw=%b pe=%b h=%b e=%b iq=%h",
               nm, got.st, got.ifu, got.lsu, got.we, got.gw, got.pe, got.h, got.e, got.iq,
               want.st, want.ifu, want.lsu, want.we, want.gw, want.pe, want.h, want.e, want.iq);
    end
  endtask

  task automatic check_lit(string nm, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    vif.ifu_rdy = 1'b0;
    vif.lsu_rdy = 1'b0;
    vif.inst_in = '0;
    @(negedge clk);
    check("reset", mk(3'd0, 32'h0));
    rst = 1'b0;
  endtask

  // Walks the expected trace, acting as fetch and data memory: ready is
  // raised after the programmed number of waits, and driven randomly while
  // the matching request is low.
  task automatic run(string nm, int limit);
    int fcnt, mcnt, pi;
    fcnt  = 0;
    mcnt  = 0;
    pi    = 0;
    n_ifu = 0;
    n_lsu = 0;
    for (int k = 0; k < exp_q.size() && k < limit; k++) begin
      check($sformatf("%s[%0d]", nm, k), exp_q[k]);
      if (vif.ifu_req) n_ifu++;
      if (vif.lsu_req) n_lsu++;
      if (vif.ifu_req && pi < p_n) begin
        vif.ifu_rdy = (fcnt == p_wf[pi]);
        vif.inst_in = p_ins[pi];
        fcnt++;
        if (vif.ifu_rdy) begin
          fcnt = 0;
          pi++;
        end
      end else begin
        vif.ifu_rdy = vif.ifu_req ? 1'b0 : 1'($urandom);
        vif.inst_in = $urandom;
        fcnt = 0;
      end
      if (vif.lsu_req && pi > 0) begin
        vif.lsu_rdy = (mcnt == p_wm[pi-1]);
        mcnt++;
      end else begin
        vif.lsu_rdy = vif.lsu_req ? 1'b0 : 1'($urandom);
        mcnt = 0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    // Single zero-wait ADDI: 1,2,3,5 then back to fetch.
    do_reset();
    p_n = 1; prog(0, ADDI, 0, 0); build();
    check_lit("model_addi_len", exp_q.size(), 5);
    check_lit("model_addi_wb_state", {29'd0, exp_q[4].st}, 5);
    run("addi", 100);
    check_lit("addi_inst_q", vif.inst_q, ADDI);

    // Load, fetch ready after 3 waits, data ready after 2 waits.
    do_reset();
    p_n = 1; prog(0, LW, 3, 2); build();
    run("load", 100);
    check_lit("load_ifu_cycles", n_ifu, 4);
    check_lit("load_lsu_cycles", n_lsu, 3);

    // Zero-wait store (5 cycles) followed by an ADDI with one fetch wait.
    do_reset();
    p_n = 2; prog(0, SW, 0, 0); prog(1, ADDI2, 1, 0); build();
    check_lit("model_store_len", exp_q.size(), 11);
    run("store", 100);

    // ebreak after an ADDI: sticky HALT with no further fetch.
    do_reset();
    p_n = 2; prog(0, ADDI, 0, 0); prog(1, EBREAK, 0, 0); build();
    run("ebreak", 100);
    check_lit("halt_state", {29'd0, vif.state}, 6);
    check_lit("halt_flag", {31'd0, vif.halt}, 1);

    // Fetch never ready: ERR after TIMEOUT cycles of FETCH.
    do_reset();
    p_n = 1; prog(0, ADDI, 255, 0); build();
    check_lit("model_tmo_len", exp_q.size(), 8);
    run("tmo_fetch", 100);
    check_lit("err_flag", {31'd0, vif.err}, 1);

    // Ready on the last allowed cycle wins, then MEM timeout to ERR.
    do_reset();
    p_n = 3; prog(0, ADDI, 3, 0); prog(1, LW, 0, 3); prog(2, LW, 0, 4); build();
    run("tmo_edge", 100);

    // Both load and store flags: behaves as a store.
    do_reset();
    ovr = 1'b1;
    p_n = 1; prog(0, ADDI, 0, 1); build();
    run("both", 100);
    ovr = 1'b0;

    // Asynchronous reset in the middle of a data access.
    do_reset();
    p_n = 1; prog(0, LW, 0, 3); build();
    run("rst_mem", 6);
    #2 rst = 1'b1;
    #1 check("async_rst", mk(3'd0, 32'h0));

    // First request after reset release comes one cycle after IDLE.
    do_reset();
    p_n = 1; prog(0, ADDI2, 0, 0); build();
    run("post_rst", 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, want finish before 200000");
    $fatal(1);
  end

endmodule
